sys_bridge_n: RTL and testbench

Parametrised successor to the microsystem CPU-to-device bridge. Decodes CPU bus accesses onto NDEV device windows and fans out one-hot write strobes. Muxes device read data back to the CPU. Adds a sequential interrupt controller: per-device edge/level capture, pending and mask registers, a cause register, and a sticky bus-error flag. Sits between mips and the timer/output/input devices in the top level.

---
 rtl/sys_bridge_n_pkg.sv | 21 ++
 rtl/sys_bridge_n_if.sv | 25 ++
 rtl/sys_bridge_n_irq_ctrl_n.sv | 63 ++++++
 rtl/sys_bridge_n.sv | 95 +++++++++
 tb/tb_sys_bridge_n.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/sys_bridge_n_pkg.sv
// Shared constants for the CPU-to-device bridge: address map, controller
// register offsets and ICAUSE field layout.
package sys_bridge_n_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SLOT_W   = 4;
  localparam int unsigned OFF_W    = 2;
  localparam int unsigned HWINT_W  = 6;

  localparam logic [23:0]       BASE_HI_DEF = 24'h00007F;
  localparam logic [SLOT_W-1:0] CTRL_SLOT   = 4'hF;

  localparam logic [OFF_W-1:0] OFF_IMASK  = 2'd0;
  localparam logic [OFF_W-1:0] OFF_IPEND  = 2'd1;
  localparam logic [OFF_W-1:0] OFF_ICAUSE = 2'd2;
  localparam logic [OFF_W-1:0] OFF_ERR    = 2'd3;

  localparam int unsigned ICAUSE_VALID_BIT = 31;
  localparam int unsigned ICAUSE_IDX_W     = 5;

endpackage

// File: rtl/sys_bridge_n_if.sv
// CPU-side and device-side bus of the bridge; master = CPU/devices, slave = bridge.
interface sys_bridge_n_if #(
  parameter int unsigned NDEV = 4
);
  logic [31:0]          pr_addr;
  logic [31:0]          pr_wd;
  logic                 pr_we;
  logic [31:0]          pr_rd;
  logic [1:0]           dev_addr;
  logic [31:0]          dev_wd;
  logic [NDEV-1:0]      dev_we;
  logic [NDEV*32-1:0]   dev_rd;
  logic [NDEV-1:0]      dev_irq;
  logic [5:0]           hwint;

  modport master (
    output pr_addr, pr_wd, pr_we, dev_rd, dev_irq,
    input  pr_rd, dev_addr, dev_wd, dev_we, hwint
  );

  modport slave (
    input  pr_addr, pr_wd, pr_we, dev_rd, dev_irq,
    output pr_rd, dev_addr, dev_wd, dev_we, hwint
  );
endinterface

// File: rtl/sys_bridge_n_irq_ctrl_n.sv
// Interrupt controller: edge/level capture, pending/mask registers,
// lowest-index cause encoder and folding of NDEV sources onto 6 CPU lines.
module irq_ctrl_n
  import sys_bridge_n_pkg::*;
#(
  parameter int unsigned     NDEV      = 4,
  parameter logic [NDEV-1:0] EDGE_MASK = NDEV'(4'b0001)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NDEV-1:0]     dev_irq,
  input  logic                mask_we,
  input  logic [NDEV-1:0]     mask_wd,
  input  logic [NDEV-1:0]     pend_clr,
  output logic [NDEV-1:0]     mask_q,
  output logic [NDEV-1:0]     pend_q,
  output logic [DATA_W-1:0]   cause_c,
  output logic [HWINT_W-1:0]  hwint_c
);

  logic [NDEV-1:0] irq_q, irq_d;
  logic [NDEV-1:0] pend_d, mask_d;
  logic [NDEV-1:0] set_c;
  logic [NDEV-1:0] active_c;

  // Edge-mode bits only fire when the previous sample was low; set beats clear.
  always_comb begin
    irq_d  = dev_irq;
    set_c  = dev_irq & ~(irq_q & EDGE_MASK);
    pend_d = set_c | (pend_q & ~pend_clr);
    mask_d = mask_we ? mask_wd : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Downward scan so the lowest active index is the last one assigned.
  always_comb begin
    active_c = pend_q & mask_q;
    cause_c  = '0;
    hwint_c  = '0;
    for (int i = int'(NDEV) - 1; i >= 0; i--) begin
      if (active_c[i]) begin
        cause_c                         = '0;
        cause_c[ICAUSE_VALID_BIT]       = 1'b1;
        cause_c[ICAUSE_IDX_W-1:0]       = ICAUSE_IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(NDEV); i++) begin
      hwint_c[i % HWINT_W] = hwint_c[i % HWINT_W] | active_c[i];
    end
  end

endmodule

// File: rtl/sys_bridge_n.sv
// CPU-to-device bridge: address decode, one-hot write strobes, read mux,
// sticky bus-error flag, and the interrupt controller instance.
module sys_bridge_n
  import sys_bridge_n_pkg::*;
#(
  parameter int unsigned     NDEV      = 4,
  parameter logic [NDEV-1:0] EDGE_MASK = NDEV'(4'b0001),
  parameter logic [23:0]     BASE_HI   = BASE_HI_DEF
) (
  input  logic            clk,
  input  logic            rst,
  sys_bridge_n_if.slave   bus
);

  logic [SLOT_W-1:0]  idx_c;
  logic               hit_c, dev_hit_c, ctrl_hit_c, unmapped_c;
  logic               ctrl_we_c;
  logic               mask_we_c;
  logic [NDEV-1:0]    pend_clr_c;
  logic [NDEV-1:0]    dev_we_c;
  logic [DATA_W-1:0]  rd_c;
  logic               err_q, err_d;
  logic [NDEV-1:0]    mask_q, pend_q;
  logic [DATA_W-1:0]  cause_c;
  logic [HWINT_W-1:0] hwint_c;
  logic               unused_c;

  assign unused_c = ^bus.pr_addr[1:0];

  always_comb begin
    idx_c      = bus.pr_addr[7:4];
    hit_c      = (bus.pr_addr[31:8] == BASE_HI);
    dev_hit_c  = hit_c && (idx_c < SLOT_W'(NDEV));
    ctrl_hit_c = hit_c && (idx_c == CTRL_SLOT);
    unmapped_c = !dev_hit_c && !ctrl_hit_c;
    ctrl_we_c  = bus.pr_we && ctrl_hit_c;
    mask_we_c  = ctrl_we_c && (bus.pr_addr[3:2] == OFF_IMASK);
    pend_clr_c = (ctrl_we_c && (bus.pr_addr[3:2] == OFF_IPEND)) ?
                 bus.pr_wd[NDEV-1:0] : '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      dev_we_c[i] = bus.pr_we && hit_c && (idx_c == SLOT_W'(i));
    end
  end

  // Set from an unmapped write wins over a clear (they cannot coincide today).
  always_comb begin
    err_d = err_q;
    if (ctrl_we_c && (bus.pr_addr[3:2] == OFF_ERR)) err_d = 1'b0;
    if (bus.pr_we && unmapped_c)                     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  always_comb begin
    rd_c = '0;
    if (dev_hit_c) begin
      for (int i = 0; i < int'(NDEV); i++) begin
        if (idx_c == SLOT_W'(i)) rd_c = bus.dev_rd[i*32 +: 32];
      end
    end else if (ctrl_hit_c) begin
      case (bus.pr_addr[3:2])
        OFF_IMASK:  rd_c = DATA_W'(mask_q);
        OFF_IPEND:  rd_c = DATA_W'(pend_q);
        OFF_ICAUSE: rd_c = cause_c;
        default:    rd_c = DATA_W'(err_q);
      endcase
    end
  end

  irq_ctrl_n #(
    .NDEV      (NDEV),
    .EDGE_MASK (EDGE_MASK)
  ) u_irq (
    .clk      (clk),
    .rst      (rst),
    .dev_irq  (bus.dev_irq),
    .mask_we  (mask_we_c),
    .mask_wd  (bus.pr_wd[NDEV-1:0]),
    .pend_clr (pend_clr_c),
    .mask_q   (mask_q),
    .pend_q   (pend_q),
    .cause_c  (cause_c),
    .hwint_c  (hwint_c)
  );

  assign bus.pr_rd    = rd_c;
  assign bus.dev_addr = bus.pr_addr[3:2];
  assign bus.dev_wd   = bus.pr_wd;
  assign bus.dev_we   = dev_we_c;
  assign bus.hwint    = hwint_c;

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench: each cycle's expected outputs are queued by the driver and
// compared by a negedge monitor.
module tb_sys_bridge_n;

  localparam int unsigned NDEV = 4;
  localparam int SEL_RD    = 0;
  localparam int SEL_WE    = 1;
  localparam int SEL_ADDR  = 2;
  localparam int SEL_WD    = 3;
  localparam int SEL_HWINT = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  sys_bridge_n_if #(.NDEV(NDEV)) bus ();

  sys_bridge_n #(
    .NDEV      (NDEV),
    .EDGE_MASK (4'b0001),
    .BASE_HI   (24'h00007F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: every presented cycle, drain the queued expectations.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        SEL_RD:    act = bus.pr_rd;
        SEL_WE:    act = 32'(bus.dev_we);
        SEL_ADDR:  act = 32'(bus.dev_addr);
        SEL_WD:    act = bus.dev_wd;
        default:   act = 32'(bus.hwint);
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [31:0] a, input logic [31:0] wd, input logic we);
    bus.pr_addr = a;
    bus.pr_wd   = wd;
    bus.pr_we   = we;
  endtask

  task automatic expv(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.dev_irq = '0;
    bus.dev_rd  = {32'h4444_0003, 32'h0000_CAFE, 32'h2222_0001, 32'h1111_0000};
    acc(32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of all controller registers
    acc(32'h0000_7FF0, 0, 0); expv("rst_imask", SEL_RD, 0); expv("rst_hwint", SEL_HWINT, 0); step();
    acc(32'h0000_7FF4, 0, 0); expv("rst_ipend", SEL_RD, 0); expv("rst_hwint", SEL_HWINT, 0); step();
    acc(32'h0000_7FF8, 0, 0); expv("rst_icause", SEL_RD, 0); step();
    acc(32'h0000_7FFC, 0, 0); expv("rst_err", SEL_RD, 0); step();

    // Device write strobe and read mux
    acc(32'h0000_7F24, 32'h1234, 1);
    expv("wr_dev_we", SEL_WE, 32'h4); expv("wr_dev_addr", SEL_ADDR, 1); expv("wr_dev_wd", SEL_WD, 32'h1234);
    step();
    acc(32'h0000_7F24, 0, 0); expv("rd_slot2", SEL_RD, 32'h0000_CAFE); expv("rd_no_we", SEL_WE, 0); step();
    acc(32'h0000_7F08, 0, 0); expv("rd_slot0", SEL_RD, 32'h1111_0000); expv("rd_addr2", SEL_ADDR, 2); step();
    acc(32'h0000_7F3C, 5, 1); expv("wr_slot3_we", SEL_WE, 32'h8); step();

    // Edge-mode capture on device 0
    acc(32'h0000_7FF0, 32'hFFFF_FFFF, 1); step();
    acc(32'h0000_7FF0, 0, 0); expv("imask_f", SEL_RD, 32'hF); step();
    bus.dev_irq = 4'b0001;
    acc(32'h0000_7FF4, 0, 0); expv("edge_n_pend", SEL_RD, 0); expv("edge_n_hwint", SEL_HWINT, 0); step();
    acc(32'h0000_7FF4, 0, 0); expv("edge_n1_pend", SEL_RD, 1); expv("edge_n1_hwint", SEL_HWINT, 1); step();
    acc(32'h0000_7FF4, 1, 1); step();
    acc(32'h0000_7FF4, 0, 0); expv("edge_clr_pend", SEL_RD, 0); expv("edge_clr_hwint", SEL_HWINT, 0); step();
    acc(32'h0000_7FF4, 0, 0); expv("edge_hold_pend", SEL_RD, 0); step();
    bus.dev_irq = 4'b0000;

    // Level-mode capture on device 1, set beats simultaneous clear
    bus.dev_irq = 4'b0010;
    acc(32'h0000_7FF4, 0, 0); expv("lvl_m_pend", SEL_RD, 0); step();
    acc(32'h0000_7FF4, 2, 1); expv("lvl_m1_hwint", SEL_HWINT, 32'h2); step();
    bus.dev_irq = 4'b0000;
    acc(32'h0000_7FF4, 0, 0); expv("lvl_setwins", SEL_RD, 2); step();
    acc(32'h0000_7FF4, 2, 1); expv("lvl_preclr_hwint", SEL_HWINT, 32'h2); step();
    acc(32'h0000_7FF4, 0, 0); expv("lvl_clr_pend", SEL_RD, 0); expv("lvl_clr_hwint", SEL_HWINT, 0); step();

    // Cause encoder and hwint folding
    bus.dev_irq = 4'b1010;
    acc(32'h0000_7FF8, 0, 0); expv("cause_empty", SEL_RD, 0); step();
    bus.dev_irq = 4'b0000;
    acc(32'h0000_7FF0, 8, 1); step();
    acc(32'h0000_7FF4, 0, 0); expv("pend_1010", SEL_RD, 32'hA); expv("hwint_m8", SEL_HWINT, 32'h08); step();
    acc(32'h0000_7FF8, 0, 0); expv("cause_m8", SEL_RD, 32'h8000_0003); step();
    acc(32'h0000_7FF8, 32'hFFFF_FFFF, 1); step();
    acc(32'h0000_7FF8, 0, 0); expv("cause_ro", SEL_RD, 32'h8000_0003); step();
    acc(32'h0000_7FF0, 32'hA, 1); step();
    acc(32'h0000_7FF8, 0, 0); expv("cause_mA", SEL_RD, 32'h8000_0001); expv("hwint_mA", SEL_HWINT, 32'h0A); step();
    acc(32'h0000_7FF0, 0, 1); step();
    acc(32'h0000_7FF8, 0, 0); expv("cause_m0", SEL_RD, 0); expv("hwint_m0", SEL_HWINT, 0); step();
    acc(32'h0000_7FF4, 32'hF, 1); step();
    acc(32'h0000_7FF4, 0, 0); expv("pend_cleared", SEL_RD, 0); step();

    // Unmapped accesses and sticky ERR
    acc(32'h0000_7F50, 32'hFF, 1); expv("unm_slot5_we", SEL_WE, 0); step();
    acc(32'h0000_7FFC, 0, 0); expv("err_set_slot5", SEL_RD, 1); step();
    acc(32'h0000_7FFC, 1, 1); step();
    acc(32'h0000_8000, 32'hFF, 1); expv("unm_base_we", SEL_WE, 0); step();
    acc(32'h0000_7FFC, 0, 0); expv("err_set_base", SEL_RD, 1); step();
    acc(32'h0000_8000, 0, 0); expv("unm_rd_base", SEL_RD, 0); step();
    acc(32'h0000_7F50, 0, 0); expv("unm_rd_slot5", SEL_RD, 0); step();
    acc(32'h0000_7FFC, 0, 0); expv("err_sticky", SEL_RD, 1); step();
    acc(32'h0000_7FFC, 0, 1); step();
    acc(32'h0000_7FFC, 0, 0); expv("err_clear", SEL_RD, 0); step();

    // Reset overrides a concurrent IMASK write
    acc(32'h0000_7FF0, 5, 1); step();
    acc(32'h0000_7FF0, 0, 0); expv("imask_5", SEL_RD, 5); step();
    rst = 1'b1;
    acc(32'h0000_7FF0, 32'hF, 1); step();
    rst = 1'b0;
    acc(32'h0000_7FF0, 0, 0); expv("imask_rst", SEL_RD, 0); expv("hwint_rst", SEL_HWINT, 0); step();

    acc(32'h0, 0, 0);
    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
